// File: rtl/scroll_engine_avalon_if.sv
// Avalon-MM slave port bundle for the scroll engine (32-bit data, 2-bit word address).
// Latency: none (wires only).
// Backpressure: none; Avalon transfers without waitrequest.
interface scroll_engine_avalon_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  chipselect,
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata
    );

    modport master (
        output chipselect,
        output read,
        output write,
        output address,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/scroll_engine_avalon.sv
// Avalon-MM scroll engine: rotates a pattern at a programmable period; wrap irq under SCROLL_IRQ_EN.
// Latency: writes act on the strobe edge, readdata is registered one cycle after chipselect&read.
// Backpressure: none; no waitrequest, every access completes immediately.
module scroll_engine_avalon #(
    parameter int DATA_WIDTH  = 32,
    parameter int SPEED_W     = 24,
    parameter int SPEED_RESET = 5000000,
    parameter int SPEED_STEP  = 250000,
    parameter int SPEED_MIN   = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    scroll_engine_avalon_if.slave avs,
    input  logic                  speedup,
    input  logic                  speeddown,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  irq
);

    localparam int POS_W = $clog2(DATA_WIDTH);
    localparam logic [SPEED_W-1:0] SPD_RST  = SPEED_W'(SPEED_RESET);
    localparam logic [SPEED_W-1:0] SPD_MIN  = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W:0]   STEP_X   = (SPEED_W+1)'(SPEED_STEP);
    localparam logic [SPEED_W:0]   MIN_X    = (SPEED_W+1)'(SPEED_MIN);
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(DATA_WIDTH - 1);

    logic [SPEED_W-1:0] speed;
    logic [SPEED_W-1:0] cnt;
    logic               en;
    logic               dir;
    logic [POS_W-1:0]   pos;
    logic               wrap;
    logic               irq_en;

    logic               wr_data, wr_speed, wr_ctrl, wr_cmd, rd_en;
    logic               step;
    logic [POS_W-1:0]   pos_nxt;
    logic [DATA_WIDTH-1:0] q_rot;
    logic [SPEED_W-1:0] speed_wr_val;
    logic [SPEED_W-1:0] speed_nxt;
    logic [SPEED_W:0]   speed_sub;
    logic [SPEED_W:0]   speed_add;
    logic               up_evt, dn_evt;
    logic [31:0]        rd_mux;

    assign rd_en    = avs.chipselect & avs.read;
    assign wr_data  = avs.chipselect & avs.write & (avs.address == 2'd0);
    assign wr_speed = avs.chipselect & avs.write & (avs.address == 2'd1);
    assign wr_ctrl  = avs.chipselect & avs.write & (avs.address == 2'd2);
    assign wr_cmd   = avs.chipselect & avs.write & (avs.address == 2'd3);

    assign step = en & (cnt == '0);

    // pos tracks how far the pattern has rotated; explicit wrap keeps non-power-of-2 widths correct
    assign pos_nxt = dir ? ((pos == '0) ? POS_LAST : pos - POS_W'(1))
                         : ((pos == POS_LAST) ? '0 : pos + POS_W'(1));
    assign q_rot   = dir ? {Q[0], Q[DATA_WIDTH-1:1]} : {Q[DATA_WIDTH-2:0], Q[DATA_WIDTH-1]};

    assign speed_wr_val = (avs.writedata[SPEED_W-1:0] < SPD_MIN) ? SPD_MIN
                                                                 : avs.writedata[SPEED_W-1:0];

    assign up_evt = speedup   | (wr_cmd & avs.writedata[0]);
    assign dn_evt = speeddown | (wr_cmd & avs.writedata[1]);

    // one extra bit exposes the borrow/carry used for saturation
    assign speed_sub = {1'b0, speed} - STEP_X;
    assign speed_add = {1'b0, speed} + STEP_X;

    always_comb begin
        speed_nxt = speed;
        if (wr_speed) begin
            speed_nxt = speed_wr_val;
        end else if (up_evt && !dn_evt) begin
            if (speed_sub[SPEED_W] || (speed_sub < MIN_X))
                speed_nxt = SPD_MIN;
            else
                speed_nxt = speed_sub[SPEED_W-1:0];
        end else if (dn_evt && !up_evt) begin
            if (speed_add[SPEED_W])
                speed_nxt = '1;
            else
                speed_nxt = speed_add[SPEED_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            2'd0: rd_mux[DATA_WIDTH-1:0] = Q;
            2'd1: rd_mux[SPEED_W-1:0]    = speed;
            2'd2: begin
                rd_mux[0] = en;
                rd_mux[1] = dir;
                rd_mux[2] = irq_en;
            end
            default: begin
                rd_mux[0]         = en;
                rd_mux[1]         = wrap;
                rd_mux[8 +: POS_W] = pos;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            Q            <= '0;
            avs.readdata <= '0;
            speed        <= SPD_RST;
            cnt          <= SPD_RST;
            en           <= 1'b0;
            dir          <= 1'b0;
            pos          <= '0;
            wrap         <= 1'b0;
        end else begin
            speed <= speed_nxt;

            if (rd_en)
                avs.readdata <= rd_mux;

            if (wr_ctrl) begin
                en  <= avs.writedata[0];
                dir <= avs.writedata[1];
            end

            // a DATA write overrides a coincident step and restarts the period
            if (wr_data) begin
                Q   <= avs.writedata[DATA_WIDTH-1:0];
                pos <= '0;
            end else if (step) begin
                Q   <= q_rot;
                pos <= pos_nxt;
            end

            if (wr_data)
                cnt <= speed;
            else if (wr_speed)
                cnt <= speed_wr_val;
            else if (en)
                cnt <= (cnt == '0) ? speed : cnt - SPEED_W'(1);

            if (step && !wr_data && (pos_nxt == '0))
                wrap <= 1'b1;
            else if (wr_cmd && avs.writedata[2])
                wrap <= 1'b0;
        end
    end

`ifdef SCROLL_IRQ_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            irq_en <= 1'b0;
        else if (wr_ctrl)
            irq_en <= avs.writedata[2];
    end

    assign irq = wrap & irq_en;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_scroll_engine_avalon.sv
// Directed bench for scroll_engine_avalon: register table, scroll timing, speed saturation, irq, reset.
module tb_scroll_engine_avalon;

    logic        clock;
    logic        resetn;
    logic        speedup;
    logic        speeddown;
    logic [31:0] Q;
    logic        irq;

    int checks = 0;
    int errors = 0;

    scroll_engine_avalon_if bus();

    scroll_engine_avalon dut (
        .clock     (clock),
        .resetn    (resetn),
        .avs       (bus),
        .speedup   (speedup),
        .speeddown (speeddown),
        .Q         (Q),
        .irq       (irq)
    );

`ifdef SCROLL_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h7;
`else
    localparam logic [31:0] CTRL_MASK = 32'h3;
`endif

    typedef struct {
        bit          do_wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clock);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clock);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clock);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    task automatic pulse(input logic up, input logic dn);
        @(negedge clock);
        speedup   = up;
        speeddown = dn;
        @(negedge clock);
        speedup   = 1'b0;
        speeddown = 1'b0;
    endtask

    // waits (bounded) for the next change of Q, then compares it
    task automatic wait_step(input string name, input logic [31:0] exp);
        logic [31:0] prev;
        int n;
        prev = Q;
        n = 0;
        while (Q == prev && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, Q, exp);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [31:0] rd;
        logic [31:0] model;
        logic        any_irq;
        int          n;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'd5000000};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
        vecs[4]  = '{1'b1, 2'd1, 32'd3,        2'd1, 32'd3};
        vecs[5]  = '{1'b1, 2'd1, 32'd0,        2'd1, 32'd1};
        vecs[6]  = '{1'b1, 2'd1, 32'h00FFFFFF, 2'd1, 32'h00FFFFFF};
        vecs[7]  = '{1'b1, 2'd2, 32'hFF,       2'd2, CTRL_MASK};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h1};
        vecs[9]  = '{1'b1, 2'd2, 32'h0,        2'd2, 32'h0};
        vecs[10] = '{1'b1, 2'd0, 32'hA5A5A5A5, 2'd0, 32'hA5A5A5A5};

        resetn         = 1'b0;
        speedup        = 1'b0;
        speeddown      = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        repeat (2) @(negedge clock);
        check("reset_q", Q, 32'h0);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wa, vecs[i].wd);
            bus_read(vecs[i].ra, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // left scroll, period 4 cycles, exact step timing
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h1);
        bus_write(2'd2, 32'h1);
        model = 32'h1;
        for (int k = 1; k <= 32; k++) begin
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("left_hold%0d", k), Q, model);
            model = {model[30:0], model[31]};
            @(posedge clock);
            #1;
            check($sformatf("left_step%0d", k), Q, model);
        end
        bus_write(2'd2, 32'h0);
        bus_read(2'd3, rd);
        check("left_status_wrap", rd, 32'h2);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        check("wrap_cleared", rd, 32'h0);

        // right scroll: wrap only after the full revolution
        bus_write(2'd2, 32'h3);
        bus_write(2'd0, 32'h1);
        wait_step("right_step1", 32'h80000000);
        bus_write(2'd2, 32'h2);
        bus_read(2'd3, rd);
        check("right_pos31", rd, 32'h1F00);
        bus_write(2'd2, 32'h3);
        model = 32'h80000000;
        for (int k = 2; k <= 31; k++) begin
            model = {model[0], model[31:1]};
            wait_step($sformatf("right_step%0d", k), model);
        end
        bus_write(2'd2, 32'h2);
        bus_read(2'd3, rd);
        check("right_no_wrap_yet", rd, 32'h0100);
        bus_write(2'd2, 32'h3);
        wait_step("right_step32", 32'h1);
        bus_write(2'd2, 32'h2);
        bus_read(2'd3, rd);
        check("right_wrap", rd, 32'h2);

        // speed adjust and saturation
        bus_write(2'd1, 32'd600000);
        pulse(1'b1, 1'b0);
        bus_read(2'd1, rd);
        check("speed_up1", rd, 32'd350000);
        repeat (3) pulse(1'b1, 1'b0);
        bus_read(2'd1, rd);
        check("speed_up_sat", rd, 32'd1);
        bus_write(2'd1, 32'd600000);
        pulse(1'b1, 1'b1);
        bus_read(2'd1, rd);
        check("speed_both", rd, 32'd600000);
        @(negedge clock);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 2'd1;
        bus.writedata  = 32'd1234;
        speeddown      = 1'b1;
        @(negedge clock);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        speeddown      = 1'b0;
        bus_read(2'd1, rd);
        check("speed_write_wins", rd, 32'd1234);
        pulse(1'b0, 1'b1);
        bus_read(2'd1, rd);
        check("speed_down", rd, 32'd251234);
        bus_write(2'd3, 32'h1);
        bus_read(2'd1, rd);
        check("speed_cmd_up", rd, 32'd1234);
        bus_write(2'd3, 32'h2);
        bus_read(2'd1, rd);
        check("speed_cmd_down", rd, 32'd251234);
        bus_write(2'd1, 32'h00FFFF00);
        pulse(1'b0, 1'b1);
        bus_read(2'd1, rd);
        check("speed_down_sat", rd, 32'h00FFFFFF);

        // read coinciding with a write to the same address returns the old value
        @(negedge clock);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 2'd1;
        bus.writedata  = 32'd77;
        @(negedge clock);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        check("rdw_old", bus.readdata, 32'h00FFFFFF);
        bus_read(2'd1, rd);
        check("rdw_new", rd, 32'd77);

        // wrap interrupt
        bus_write(2'd3, 32'h4);
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h1);
        bus_write(2'd2, 32'h5);
`ifdef SCROLL_IRQ_EN
        n = 0;
        while (!irq && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("irq_assert", {31'h0, irq}, 32'h1);
        check("irq_on_wrap_q", Q, 32'h1);
        bus_write(2'd3, 32'h4);
        check("irq_cleared", {31'h0, irq}, 32'h0);
`else
        any_irq = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clock);
            #1;
            any_irq = any_irq | irq;
        end
        check("irq_tied_low", {31'h0, any_irq}, 32'h0);
        bus_read(2'd3, rd);
        check("wrap_without_irq", rd & 32'h2, 32'h2);
`endif
        bus_write(2'd2, 32'h0);

        // DATA write landing on a step edge wins
        bus_write(2'd3, 32'h4);
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h1);
        bus_write(2'd2, 32'h1);
        repeat (2) @(negedge clock);
        bus_write(2'd0, 32'hF0);
        check("data_vs_step_q", Q, 32'hF0);
        bus_write(2'd2, 32'h0);
        bus_read(2'd3, rd);
        check("data_vs_step_status", rd, 32'h0);

        // asynchronous reset mid-scroll
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'hF);
        bus_read(2'd1, rd);
        bus_write(2'd2, 32'h1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_q", Q, 32'h0);
        check("async_rst_readdata", bus.readdata, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("post_rst_hold", Q, 32'h0);
        bus_read(2'd2, rd);
        check("post_rst_ctrl", rd, 32'h0);
        bus_read(2'd1, rd);
        check("post_rst_speed", rd, 32'd5000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
